// File: rtl/fifo_drv_pkg.sv
// fifo_drv_pkg: shared types and helpers for the FIFO stream driver.
package fifo_drv_pkg;

    localparam int unsigned DRV_DW = 16;
    localparam int unsigned DRV_CW = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } drv_state_t;

    // Word k of a burst is seed + k, wrapping modulo 2^DRV_DW.
    function automatic logic [DRV_DW-1:0] next_word(input logic [DRV_DW-1:0] seed,
                                                    input logic [DRV_CW-1:0] idx);
        return seed + DRV_DW'(idx);
    endfunction

endpackage

// File: rtl/fifo_drv_credit.sv
// fifo_drv_credit: write/read word accounting for the FIFO stream driver.
// Reports whether another write or read may be issued on the next cycle, evaluated on the
// counter values that will hold after the current clock edge.
module fifo_drv_credit #(
    parameter int unsigned CW = 16
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          wen_i,
    input  logic          ren_i,
    input  logic          valid_i,
    input  logic [CW-1:0] num_words_i,
    input  logic [CW-1:0] depth_i,
    output logic [CW-1:0] rd_cnt_o,
    output logic [CW-1:0] wr_cnt_next_o,
    output logic [CW-1:0] rd_cnt_next_o,
    output logic          rd_hit_o,
    output logic          can_write_o,
    output logic          can_read_o
);

    logic [CW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CW-1:0] rd_cnt_q, rd_cnt_d;
    logic [CW-1:0] rd_iss_q, rd_iss_d;
    logic [CW-1:0] occ_d;
    logic          ren_d1_q;
    logic          rd_miss;

    // Next counter values and issue eligibility for the following cycle.
    always_comb begin
        rd_hit_o = ren_d1_q & valid_i;
        rd_miss  = ren_d1_q & ~valid_i;
        if (clr_i) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            rd_iss_d = '0;
        end else begin
            wr_cnt_d = wr_cnt_q + CW'(wen_i);
            rd_cnt_d = rd_cnt_q + CW'(rd_hit_o);
            // A read answered without valid is withdrawn so it gets re-issued.
            rd_iss_d = rd_iss_q + CW'(ren_i) - CW'(rd_miss);
        end
        occ_d       = wr_cnt_d - rd_cnt_d;
        can_write_o = (wr_cnt_d < num_words_i) && (occ_d < depth_i);
        can_read_o  = (occ_d != '0) && (rd_iss_d == rd_cnt_d);
    end

    // Counter state; ren_d1 tracks the single read in flight (read latency 1).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            rd_iss_q <= '0;
            ren_d1_q <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            rd_iss_q <= rd_iss_d;
            ren_d1_q <= clr_i ? 1'b0 : ren_i;
        end
    end

    assign rd_cnt_o      = rd_cnt_q;
    assign wr_cnt_next_o = wr_cnt_d;
    assign rd_cnt_next_o = rd_cnt_d;

endmodule

// File: rtl/fifo_stream_driver.sv
// fifo_stream_driver: pushes a counted incrementing-data burst into memory_core (FIFO mode)
// and drains it, never exceeding the configured depth outstanding.
// Optional build macro FIFO_DRV_CHECK_EN adds the read-data comparator behind mismatch.
module fifo_stream_driver
    import fifo_drv_pkg::*;
#(
    parameter int unsigned DW = DRV_DW,
    parameter int unsigned CW = DRV_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] num_words,
    input  logic [DW-1:0] seed,
    input  logic [CW-1:0] depth,
    output logic          wen_in,
    output logic [DW-1:0] data_in,
    output logic          ren_in,
    input  logic [DW-1:0] data_out,
    input  logic          valid_out,
    output logic          clk_en,
    output logic          busy,
    output logic          done,
    output logic          mismatch
);

    drv_state_t    state_q, state_d;
    logic [CW-1:0] nw_q, depth_q, nw_cfg, depth_cfg;
    logic [DW-1:0] seed_q, seed_cfg;
    logic          wen_q, ren_q, clk_en_q, busy_q, done_q;
    logic [DW-1:0] data_q;
    logic          accept, wen_d, ren_d, act_d;
    logic [CW-1:0] rd_cnt, wr_next, rd_next;
    logic          rd_hit, can_write, can_read;

    fifo_drv_credit #(
        .CW(CW)
    ) u_credit (
        .clk_i        (clk),
        .reset_i      (reset),
        .clr_i        (accept),
        .wen_i        (wen_q),
        .ren_i        (ren_q),
        .valid_i      (valid_out),
        .num_words_i  (nw_cfg),
        .depth_i      (depth_cfg),
        .rd_cnt_o     (rd_cnt),
        .wr_cnt_next_o(wr_next),
        .rd_cnt_next_o(rd_next),
        .rd_hit_o     (rd_hit),
        .can_write_o  (can_write),
        .can_read_o   (can_read)
    );

    // Next state and next registered strobes; a fresh start uses the live config inputs.
    always_comb begin
        accept    = start && (state_q == IDLE);
        nw_cfg    = accept ? num_words : nw_q;
        depth_cfg = accept ? depth : depth_q;
        seed_cfg  = accept ? seed : seed_q;
        state_d   = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = (num_words == '0) ? DONE : RUN;
            RUN:     if (wr_next == nw_cfg) state_d = DRAIN;
            DRAIN:   if (rd_next == nw_cfg) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        act_d = (state_d == RUN) || (state_d == DRAIN);
        wen_d = (state_d == RUN) && can_write;
        ren_d = act_d && can_read;
    end

    // FSM state, latched burst config and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            nw_q     <= '0;
            depth_q  <= '0;
            seed_q   <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            data_q   <= '0;
            clk_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                nw_q    <= num_words;
                depth_q <= depth;
                seed_q  <= seed;
            end
            wen_q <= wen_d;
            ren_q <= ren_d;
            if (wen_d) data_q <= next_word(seed_cfg, wr_next);
            clk_en_q <= act_d;
            busy_q   <= act_d;
            done_q   <= (state_d == DONE);
        end
    end

    assign wen_in  = wen_q;
    assign ren_in  = ren_q;
    assign data_in = data_q;
    assign clk_en  = clk_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef FIFO_DRV_CHECK_EN
    logic          mismatch_q;
    logic [DW-1:0] exp_word;

    assign exp_word = next_word(seed_q, rd_cnt);

    // Sticky compare of every counted read against its expected word.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            mismatch_q <= 1'b0;
        end else if (rd_hit && (data_out != exp_word)) begin
            mismatch_q <= 1'b1;
        end
    end

    assign mismatch = mismatch_q;
`else
    logic unused_chk;

    assign unused_chk = ^{data_out, rd_cnt, rd_hit};
    assign mismatch   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_driver.sv
// Bench for fifo_stream_driver: a memory_core FIFO model answers reads with latency 1, a
// reference model built from bench-side word counts predicts every strobe, and a scoreboard
// of expected write words is checked as the DUT writes.
module tb_fifo_stream_driver;

    localparam int DW = 16;
    localparam int CW = 16;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic [DW-1:0] seed      = '0;
    logic [CW-1:0] depth     = '0;
    logic [DW-1:0] data_out  = '0;
    logic          valid_out = 1'b0;
    logic          wen_in, ren_in, clk_en, busy, done, mismatch;
    logic [DW-1:0] data_in;

    fifo_stream_driver #(
        .DW(DW),
        .CW(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .num_words(num_words),
        .seed     (seed),
        .depth    (depth),
        .wen_in   (wen_in),
        .data_in  (data_in),
        .ren_in   (ren_in),
        .data_out (data_out),
        .valid_out(valid_out),
        .clk_en   (clk_en),
        .busy     (busy),
        .done     (done),
        .mismatch (mismatch)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem_q[$];
    logic [DW-1:0] pend_data = '0;
    int w = 0, r = 0, m_nw = 0, m_dep = 0, rd_ret = 0, corrupt_at = -1, stall_pct = 0;
    bit active = 0, done_seen = 0, prev_ren = 0, pend_ok = 0;
    bit stall_all = 0, spur_en = 0, exp_mm = 0;
    bit e_wen, e_ren, e_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + memory model, sampling on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            mem_q.delete();
            pend_ok   = 0;
            prev_ren  = 0;
            valid_out = 1'b0;
            data_out  = '0;
        end else begin
            e_wen  = active && (w < m_nw) && (w - r < m_dep);
            e_ren  = active && (w - r > 0) && !prev_ren;
            e_done = active && (w == m_nw) && (r == m_nw);
            check("wen_in", wen_in, e_wen);
            check("ren_in", ren_in, e_ren);
            check("done", done, e_done);
            check("busy", busy, active && !e_done);
            check("clk_en", clk_en, active && !e_done);
            check("mismatch", mismatch, exp_mm);

            valid_out = 1'b0;
            data_out  = DW'($urandom);
            if (prev_ren) begin
                if (pend_ok) begin
                    valid_out = 1'b1;
                    data_out  = pend_data;
                    if (rd_ret == corrupt_at) begin
                        data_out = data_out ^ 16'h0100;
`ifdef FIFO_DRV_CHECK_EN
                        exp_mm = 1;
`endif
                    end
                    rd_ret++;
                    r++;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                valid_out = 1'b1;
            end

            if (ren_in) begin
                pend_ok = !(stall_all || ($urandom_range(0, 99) < stall_pct));
                if (pend_ok) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rd_underflow: got read at occupancy 0 expected occupancy >0 at %0t",
                                 $time);
                        pend_ok = 0;
                    end else begin
                        pend_data = mem_q.pop_front();
                    end
                end
            end

            if (wen_in) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_write: got write of %0h expected no write at %0t",
                             data_in, $time);
                end else begin
                    check("data_in", data_in, exp_q.pop_front());
                end
                mem_q.push_back(data_in);
                w++;
            end

            prev_ren = ren_in;
            if (e_done) begin
                active    = 0;
                done_seen = 1;
            end
        end
    end

    task automatic start_burst(input int nw, input logic [DW-1:0] sd, input int dep,
                               input int spct, input int cor, input bit spur);
        @(posedge clk);
        #2;
        start     = 1'b1;
        num_words = CW'(nw);
        seed      = sd;
        depth     = CW'(dep);
        @(posedge clk);
        #2;
        // Scramble config after the accepting edge; the DUT must use its latched copy.
        start     = 1'b0;
        num_words = CW'($urandom);
        seed      = DW'($urandom);
        depth     = CW'($urandom);
        exp_q.delete();
        for (int k = 0; k < nw; k++) exp_q.push_back(sd + DW'(k));
        m_nw       = nw;
        m_dep      = dep;
        w          = 0;
        r          = 0;
        rd_ret     = 0;
        corrupt_at = cor;
        stall_pct  = spct;
        spur_en    = spur;
        exp_mm     = 0;
        done_seen  = 0;
        active     = 1;
    endtask

    task automatic finish_burst(input int hold, input bit glitch);
        if (hold > 0) begin
            stall_all = 1;
            repeat (hold) @(posedge clk);
            #2;
            check("stall_writes", w, (m_dep < m_nw) ? m_dep : m_nw);
            stall_all = 0;
        end
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            @(posedge clk);
            #2;
            if (glitch && m_nw >= 8 && c == 3) begin
                start     = 1'b1;
                num_words = CW'($urandom_range(1, 20));
                depth     = CW'($urandom_range(1, 6));
                seed      = DW'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checks++;
        if (!done_seen) begin
            failures++;
            $display("FAIL timeout: got no done within 3000 cycles expected done, w=%0d r=%0d", w, r);
            active = 0;
        end
        check("writes_left", exp_q.size(), 0);
    endtask

    task automatic run_burst(input int nw, input logic [DW-1:0] sd, input int dep,
                             input int spct, input int cor, input bit spur, input int hold,
                             input bit glitch);
        start_burst(nw, sd, dep, spct, cor, spur);
        finish_burst(hold, glitch);
    endtask

    task automatic check_idle_outputs();
        check("rst_wen", wen_in, 0);
        check("rst_ren", ren_in, 0);
        check("rst_clk_en", clk_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_data_in", data_in, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs();
        reset = 1'b0;

        run_burst(3, 16'h0010, 4, 0, -1, 0, 0, 0);   // basic burst
        run_burst(6, 16'h1234, 2, 0, -1, 0, 12, 0);  // read side stalled, depth limit
        run_burst(0, 16'hABCD, 3, 0, -1, 0, 0, 0);   // empty burst
        run_burst(4, 16'hFFFE, 3, 20, -1, 0, 0, 0);  // data wrap
        run_burst(5, 16'h0200, 3, 0, 1, 0, 0, 0);    // corrupted second read
        run_burst(2, 16'h0300, 1, 0, -1, 1, 0, 0);   // start clears mismatch

        // Reset mid-burst, then a clean rerun.
        start_burst(6, 16'h0500, 4, 0, -1, 0);
        for (int c = 0; c < 50 && w < 3; c++) @(posedge clk);
        #2;
        reset  = 1'b1;
        active = 0;
        exp_q.delete();
        exp_mm = 0;
        @(posedge clk);
        #2;
        check_idle_outputs();
        reset = 1'b0;
        run_burst(3, 16'h0010, 4, 0, -1, 0, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_burst($urandom_range(0, 14), DW'($urandom), $urandom_range(1, 5),
                      $urandom_range(0, 50),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
                      1, 0, (i % 3) == 0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
